// File: rtl/count_pkg.sv
// Shared constants, state encoding and helpers for the BCD count sequencer.
package count_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd0;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Saturate a non-BCD nibble to the largest legal digit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter digit with synchronous load and up/down stepping.
module bcd_digit
    import count_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] q,
    output logic               term
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= DIGIT_MIN;
        end else if (load) begin
            q <= load_val;
        end else if (enable) begin
            if (dir == DIR_UP) begin
                q <= (q == DIGIT_MAX) ? DIGIT_MIN : q + 4'd1;
            end else begin
                q <= (q == DIGIT_MIN) ? DIGIT_MAX : q - 4'd1;
            end
        end
    end

    // Terminal value: this digit will carry/borrow into the next one on a step.
    assign term = (dir == DIR_UP) ? (q == DIGIT_MAX) : (q == DIGIT_MIN);

endmodule

// File: rtl/count_sequencer.sv
// Multi-digit BCD up/down count sequencer with run/pause/done control FSM.
module count_sequencer
    import count_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Stop,
    input  logic                      Select,
    input  logic                      Load,
    input  logic [DIGIT_W*DIGITS-1:0] LoadValue,
    input  logic                      Tick,
    output logic [DIGIT_W*DIGITS-1:0] Count,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Overflow
);

    localparam int unsigned CW = DIGIT_W * DIGITS;

    localparam logic [CW-1:0] ALL_ZERO = '0;
    localparam logic [CW-1:0] ALL_ONE  = CW'(1);
    localparam logic [CW-1:0] ALL_NINE = {DIGITS{DIGIT_MAX}};

    state_t          state;
    state_t          state_next;
    logic            dir;
    logic            dir_next;
    logic            busy_next;
    logic            done_next;
    logic            ovf_next;
    logic            step_en;
    logic            load_en;
    logic [CW-1:0]   clamped;
    logic [CW-1:0]   eff_count;
    logic [DIGITS-1:0] en;
    logic [DIGITS-1:0] term;

    // Clamp each preset digit to 9.
    always_comb begin
        clamped = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(LoadValue[i*DIGIT_W +: DIGIT_W]);
        end
    end

    // Value the counter will hold once a same-cycle load has taken effect.
    assign eff_count = Load ? clamped : Count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            dir      <= DIR_UP;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_next;
            dir      <= dir_next;
            Busy     <= busy_next;
            Done     <= done_next;
            Overflow <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        dir_next   = dir;
        done_next  = 1'b0;
        ovf_next   = 1'b0;
        step_en    = 1'b0;
        load_en    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                load_en = Load;
                if (Start) begin
                    dir_next = Select;
                    if (Select == DIR_DOWN && eff_count == ALL_ZERO) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Stop wins over Tick; a down run never steps below zero.
                if (Stop) begin
                    state_next = ST_PAUSE;
                end else if (Tick && !(dir == DIR_DOWN && Count == ALL_ZERO)) begin
                    step_en = 1'b1;
                    if (dir == DIR_DOWN && Count == ALL_ONE) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                    if (dir == DIR_UP && Count == ALL_NINE) begin
                        ovf_next = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                load_en = Load;
                if (Stop) begin
                    state_next = ST_IDLE;
                end else if (Start) begin
                    if (dir == DIR_DOWN && eff_count == ALL_ZERO) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next == ST_RUN) || (state_next == ST_PAUSE);
    end

    // Synchronous cascade: a digit steps only when all lower digits are terminal.
    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        if (i == 0) begin : g_first
            assign en[i] = step_en;
        end else begin : g_rest
            assign en[i] = step_en & (&term[i-1:0]);
        end

        bcd_digit u_digit (
            .clk      (Clock),
            .rst      (Reset),
            .enable   (en[i]),
            .dir      (dir),
            .load     (load_en),
            .load_val (clamped[i*DIGIT_W +: DIGIT_W]),
            .q        (Count[i*DIGIT_W +: DIGIT_W]),
            .term     (term[i])
        );
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with DIGITS=3.
module tb_count_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        sel;
    logic        load;
    logic [11:0] load_value;
    logic        tick;
    logic [11:0] count;
    logic        busy;
    logic        done;
    logic        overflow;

    typedef struct packed {
        logic [11:0] count;
        logic        busy;
        logic        done;
        logic        ovf;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clock = ~clock;

    count_sequencer #(.DIGITS(3)) dut (
        .Clock     (clock),
        .Reset     (reset),
        .Start     (start),
        .Stop      (stop),
        .Select    (sel),
        .Load      (load),
        .LoadValue (load_value),
        .Tick      (tick),
        .Count     (count),
        .Busy      (busy),
        .Done      (done),
        .Overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Apply one cycle of inputs, queue its expected outcome, then compare after the edge.
    task automatic cyc(input logic rs, input logic st, input logic sp, input logic se,
                       input logic ld, input logic [11:0] lv, input logic tk,
                       input logic [11:0] ec, input logic eb, input logic ed, input logic eo,
                       input string tag);
        exp_t  e;
        string t;
        reset = rs; start = st; stop = sp; sel = se; load = ld; load_value = lv; tick = tk;
        sb_q.push_back({ec, eb, ed, eo});
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".count"}, 32'(count), 32'(e.count));
        check({t, ".busy"},  32'(busy),  32'(e.busy));
        check({t, ".done"},  32'(done),  32'(e.done));
        check({t, ".ovf"},   32'(overflow), 32'(e.ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; sel = 1'b0;
        load = 1'b0; load_value = '0; tick = 1'b0;
        //   rs st sp se ld lv      tk  count   bz dn ov
        cyc(1, 1, 0, 0, 1, 12'h123, 1, 12'h000, 0, 0, 0, "rst_prio");
        cyc(0, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0, "idle");

        // Down run from 005 to DONE
        cyc(0, 0, 0, 0, 1, 12'h005, 0, 12'h005, 0, 0, 0, "ld005");
        cyc(0, 1, 0, 1, 0, 12'h000, 0, 12'h005, 1, 0, 0, "start_dn");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h004, 1, 0, 0, "dn4");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h003, 1, 0, 0, "dn3");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h002, 1, 0, 0, "dn2");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h001, 1, 0, 0, "dn1");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h000, 0, 1, 0, "dn0");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h000, 0, 0, 0, "done_hold");

        // Up wrap from 998 with overflow
        cyc(0, 0, 0, 0, 1, 12'h998, 0, 12'h998, 0, 0, 0, "ld998");
        cyc(0, 1, 0, 0, 0, 12'h000, 0, 12'h998, 1, 0, 0, "start_up");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h999, 1, 0, 0, "up999");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h000, 1, 0, 1, "wrap");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h001, 1, 0, 0, "after_wrap");
        cyc(0, 0, 1, 0, 0, 12'h000, 0, 12'h001, 1, 0, 0, "pause1");
        cyc(0, 0, 1, 0, 0, 12'h000, 0, 12'h001, 0, 0, 0, "idle1");

        // Clamp and two-digit carry
        cyc(0, 0, 0, 0, 1, 12'h0A7, 0, 12'h097, 0, 0, 0, "clamp");
        cyc(0, 1, 0, 0, 0, 12'h000, 0, 12'h097, 1, 0, 0, "start_up2");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h098, 1, 0, 0, "up98");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h099, 1, 0, 0, "up99");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h100, 1, 0, 0, "carry100");
        cyc(0, 0, 1, 0, 0, 12'h000, 0, 12'h100, 1, 0, 0, "pause2");
        cyc(0, 0, 1, 0, 0, 12'h000, 0, 12'h100, 0, 0, 0, "idle2");

        // Pause priority, direction kept across pause, load ignored in RUN
        cyc(0, 0, 0, 0, 1, 12'h020, 0, 12'h020, 0, 0, 0, "ld020");
        cyc(0, 1, 0, 1, 0, 12'h000, 0, 12'h020, 1, 0, 0, "start_dn2");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h019, 1, 0, 0, "borrow19");
        cyc(0, 0, 1, 0, 0, 12'h000, 1, 12'h019, 1, 0, 0, "stop_tick");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h019, 1, 0, 0, "pause_hold");
        cyc(0, 1, 0, 0, 0, 12'h000, 0, 12'h019, 1, 0, 0, "resume");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h018, 1, 0, 0, "dn18");
        cyc(0, 0, 0, 0, 1, 12'h555, 0, 12'h018, 1, 0, 0, "ld_in_run");
        cyc(0, 0, 1, 0, 0, 12'h000, 0, 12'h018, 1, 0, 0, "pause3");
        cyc(0, 0, 1, 0, 0, 12'h000, 0, 12'h018, 0, 0, 0, "idle3");

        // Reset mid-run, then start right after reset with a same-cycle load
        cyc(0, 0, 0, 0, 1, 12'h455, 0, 12'h455, 0, 0, 0, "ld455");
        cyc(0, 1, 0, 0, 0, 12'h000, 0, 12'h455, 1, 0, 0, "start_up3");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h456, 1, 0, 0, "up456");
        cyc(1, 0, 0, 0, 0, 12'h000, 1, 12'h000, 0, 0, 0, "rst_run");
        cyc(0, 1, 0, 0, 1, 12'h003, 0, 12'h003, 1, 0, 0, "ld_start");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h004, 1, 0, 0, "up4");
        cyc(1, 1, 0, 0, 1, 12'h777, 1, 12'h000, 0, 0, 0, "rst_ld");

        // Down start at zero goes straight to DONE
        cyc(0, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 1, 0, "zero_start");
        cyc(0, 0, 0, 0, 0, 12'h000, 1, 12'h000, 0, 0, 0, "zero_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
